// File: rtl/hkr_bus_pkg.sv
// Shared types and constants for the CPU-bus to asynchronous SRAM responder.
package hkr_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } bus_state_t;

    localparam int unsigned WAIT_CYCLE_DEFAULT = 4;
    localparam int unsigned WAIT_CNT_W         = 4;

    // Strobe levels driven whenever the SRAM is not being accessed.
    localparam logic       CE_N_IDLE = 1'b1;
    localparam logic       OE_N_IDLE = 1'b1;
    localparam logic       WE_N_IDLE = 1'b1;
    localparam logic [3:0] BE_N_IDLE = 4'b1111;

    function automatic logic is_access(input bus_state_t s);
        return (s == ST_READ) || (s == ST_WRITE);
    endfunction

endpackage

// File: rtl/sram_wait_timer.sv
// Access-length timer: loads a start value, counts down once per cycle while
// enabled, and flags the cycle in which an enabled count sits at zero.
module sram_wait_timer #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] count_o,
    output logic             expired_o
);

    logic [CNT_W-1:0] cnt_q;

    // Load has priority; decrement saturates at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign count_o   = cnt_q;
    assign expired_o = dec_i && (cnt_q == '0);

endmodule

// File: rtl/bus_sram_responder.sv
// CPU bus slave fronting an asynchronous SRAM with a fixed access length.
// Optional feature: define BUS_PROTOCOL_CHECK_EN to build the sticky bus_err
// protocol checker; otherwise bus_err is tied low and no checker exists.
module bus_sram_responder
    import hkr_bus_pkg::*;
#(
    parameter int unsigned WAIT_CYCLE = WAIT_CYCLE_DEFAULT,
    parameter int unsigned ADDR_W     = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       bus_addr,
    input  logic [3:0]        bus_byte_en,
    input  logic              bus_read,
    input  logic              bus_write,
    input  logic [31:0]       bus_write_data,
    output logic [31:0]       bus_read_data,
    output logic              bus_stall,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_data_o,
    input  logic [31:0]       sram_data_i,
    output logic              sram_data_oe,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic [3:0]        sram_be_n,
    output logic              bus_err
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WAIT_CYCLE - 1);

    bus_state_t            state_q, state_d;
    logic                  bus_req;
    logic                  timer_load, timer_dec, expired;
    logic [WAIT_CNT_W-1:0] cnt;
    logic                  next_last;

    logic [31:0]           rdata_q;
    logic [ADDR_W-1:0]     addr_q;
    logic [31:0]           wdata_q;
    logic                  data_oe_q, ce_n_q, oe_n_q, we_n_q;
    logic [3:0]            be_n_q;

    logic                  unused_addr_bits;
    assign unused_addr_bits = ^{bus_addr[31:ADDR_W+2], bus_addr[1:0]};

    assign bus_req    = bus_read | bus_write;
    assign bus_stall  = bus_req & (state_q != ST_DONE);
    assign timer_load = (state_q == ST_IDLE) && bus_req;
    assign timer_dec  = is_access(state_q);

    sram_wait_timer #(
        .CNT_W (WAIT_CNT_W)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (timer_load),
        .load_val_i (WAIT_LOAD),
        .dec_i      (timer_dec),
        .count_o    (cnt),
        .expired_o  (expired)
    );

    // Next-state selection; write wins over read, a dropped request aborts.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus_write) begin
                    state_d = ST_WRITE;
                end else if (bus_read) begin
                    state_d = ST_READ;
                end
            end
            ST_READ, ST_WRITE: begin
                if (!bus_req) begin
                    state_d = ST_IDLE;
                end else if (expired) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // True when the upcoming access cycle is the final one of the transaction.
    // Write strobe is withheld there so data is held past the rising we_n.
    always_comb begin
        next_last = (state_q == ST_IDLE) ? (WAIT_LOAD == '0) : (cnt == WAIT_CNT_W'(1));
    end

    // State register with SRAM strobes and bus data registered from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            rdata_q   <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            data_oe_q <= 1'b0;
            ce_n_q    <= CE_N_IDLE;
            oe_n_q    <= OE_N_IDLE;
            we_n_q    <= WE_N_IDLE;
            be_n_q    <= BE_N_IDLE;
        end else begin
            state_q   <= state_d;
            ce_n_q    <= is_access(state_d) ? 1'b0 : CE_N_IDLE;
            oe_n_q    <= (state_d == ST_READ) ? 1'b0 : OE_N_IDLE;
            we_n_q    <= ((state_d == ST_WRITE) && !next_last) ? 1'b0 : WE_N_IDLE;
            data_oe_q <= (state_d == ST_WRITE);
            unique case (state_d)
                ST_READ:  be_n_q <= 4'b0000;
                ST_WRITE: be_n_q <= ~bus_byte_en;
                default:  be_n_q <= BE_N_IDLE;
            endcase
            if ((state_q == ST_IDLE) && (state_d != ST_IDLE)) begin
                addr_q <= bus_addr[ADDR_W+1:2];
            end
            if ((state_q == ST_IDLE) && (state_d == ST_WRITE)) begin
                wdata_q <= bus_write_data;
            end
            if ((state_q == ST_READ) && (state_d == ST_DONE)) begin
                rdata_q <= sram_data_i;
            end
        end
    end

    assign bus_read_data = rdata_q;
    assign sram_addr     = addr_q;
    assign sram_data_o   = wdata_q;
    assign sram_data_oe  = data_oe_q;
    assign sram_ce_n     = ce_n_q;
    assign sram_oe_n     = oe_n_q;
    assign sram_we_n     = we_n_q;
    assign sram_be_n     = be_n_q;

`ifdef BUS_PROTOCOL_CHECK_EN
    logic        err_q;
    logic        prev_stall_q, prev_rd_q, prev_wr_q;
    logic [31:0] prev_addr_q;

    // Sticky error on dropped requests, dual requests, or request changes under stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q        <= 1'b0;
            prev_stall_q <= 1'b0;
            prev_rd_q    <= 1'b0;
            prev_wr_q    <= 1'b0;
            prev_addr_q  <= '0;
        end else begin
            prev_stall_q <= bus_stall;
            prev_rd_q    <= bus_read;
            prev_wr_q    <= bus_write;
            prev_addr_q  <= bus_addr;
            if ((is_access(state_q) && !bus_req) ||
                ((state_q == ST_IDLE) && bus_read && bus_write) ||
                (prev_stall_q && ((bus_addr != prev_addr_q) ||
                                  (bus_read != prev_rd_q) ||
                                  (bus_write != prev_wr_q)))) begin
                err_q <= 1'b1;
            end
        end
    end

    assign bus_err = err_q;
`else
    assign bus_err = 1'b0;
`endif

endmodule

// File: tb/tb_bus_sram_responder.sv
// Self-checking bench for bus_sram_responder (WAIT_CYCLE=4 main instance plus
// a WAIT_CYCLE=1 instance). Expected bus_err follows BUS_PROTOCOL_CHECK_EN.
module tb_bus_sram_responder;

    localparam int unsigned W = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] bus_addr, bus_write_data, bus_read_data;
    logic [3:0]  bus_byte_en;
    logic        bus_read, bus_write, bus_stall, bus_err;
    logic [19:0] sram_addr;
    logic [31:0] sram_data_o, sram_data_i;
    logic        sram_data_oe, sram_ce_n, sram_oe_n, sram_we_n;
    logic [3:0]  sram_be_n;

    logic [31:0] d1_bus_addr, d1_bus_write_data, d1_bus_read_data, d1_sram_data_o;
    logic [3:0]  d1_bus_byte_en, d1_sram_be_n;
    logic        d1_bus_read, d1_bus_write, d1_bus_stall, d1_bus_err;
    logic [19:0] d1_sram_addr;
    logic        d1_sram_data_oe, d1_sram_ce_n, d1_sram_oe_n, d1_sram_we_n;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    logic        mem_init;
    logic [31:0] sram_mem [256];
    logic [31:0] ref_mem  [256];
    logic [31:0] exp_rdata;
    logic        exp_err;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bus_sram_responder #(.WAIT_CYCLE(W), .ADDR_W(20)) dut (
        .clk(clk), .rst(rst), .bus_addr(bus_addr), .bus_byte_en(bus_byte_en),
        .bus_read(bus_read), .bus_write(bus_write), .bus_write_data(bus_write_data),
        .bus_read_data(bus_read_data), .bus_stall(bus_stall), .sram_addr(sram_addr),
        .sram_data_o(sram_data_o), .sram_data_i(sram_data_i), .sram_data_oe(sram_data_oe),
        .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
        .sram_be_n(sram_be_n), .bus_err(bus_err)
    );

    bus_sram_responder #(.WAIT_CYCLE(1), .ADDR_W(20)) dut1 (
        .clk(clk), .rst(rst), .bus_addr(d1_bus_addr), .bus_byte_en(d1_bus_byte_en),
        .bus_read(d1_bus_read), .bus_write(d1_bus_write), .bus_write_data(d1_bus_write_data),
        .bus_read_data(d1_bus_read_data), .bus_stall(d1_bus_stall), .sram_addr(d1_sram_addr),
        .sram_data_o(d1_sram_data_o), .sram_data_i(32'h0), .sram_data_oe(d1_sram_data_oe),
        .sram_ce_n(d1_sram_ce_n), .sram_oe_n(d1_sram_oe_n), .sram_we_n(d1_sram_we_n),
        .sram_be_n(d1_sram_be_n), .bus_err(d1_bus_err)
    );

    function automatic logic [31:0] init_word(input int unsigned i);
        return (i == 4) ? 32'hDEADBEEF : (32'h5A000000 | (i * 32'h00010203));
    endfunction

    // Asynchronous SRAM model: byte-lane writes while ce_n and we_n are low.
    assign sram_data_i = sram_mem[sram_addr[7:0]];
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) sram_mem[i] <= init_word(i);
        end else if (!sram_ce_n && !sram_we_n) begin
            for (int b = 0; b < 4; b++)
                if (!sram_be_n[b]) sram_mem[sram_addr[7:0]][b*8 +: 8] <= sram_data_o[b*8 +: 8];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // One isolated or back-to-back transaction on the main instance; called at posedge+1.
    task automatic txn(input bit wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        logic [19:0] w;
        logic [31:0] exp_rd;
        w = a[21:2];
        exp_rd = ref_mem[w[7:0]];
        bus_addr = a; bus_write_data = d; bus_byte_en = be;
        bus_write = wr; bus_read = !wr;
        for (int k = 0; k <= W + 1; k++) begin
            @(negedge clk);
            check("stall", {31'b0, bus_stall}, {31'b0, (k <= W)});
            if (k >= 1 && k <= W) begin
                check("ce_n", {31'b0, sram_ce_n}, 32'd0);
                check("addr", {12'b0, sram_addr}, {12'b0, w});
                if (wr) begin
                    check("we_n", {31'b0, sram_we_n}, {31'b0, (k == W)});
                    check("oe", {31'b0, sram_data_oe}, 32'd1);
                    check("wr_be_n", {28'b0, sram_be_n}, {28'b0, ~be});
                    check("data_o", sram_data_o, d);
                    check("wr_oe_n", {31'b0, sram_oe_n}, 32'd1);
                end else begin
                    check("rd_oe_n", {31'b0, sram_oe_n}, 32'd0);
                    check("rd_be_n", {28'b0, sram_be_n}, 32'd0);
                    check("rd_we_n", {31'b0, sram_we_n}, 32'd1);
                    check("rd_oe", {31'b0, sram_data_oe}, 32'd0);
                end
            end else begin
                check("idle_ce_n", {31'b0, sram_ce_n}, 32'd1);
                check("idle_we_n", {31'b0, sram_we_n}, 32'd1);
                check("idle_oe", {31'b0, sram_data_oe}, 32'd0);
            end
            if (k == W + 1 && !wr) exp_rdata = exp_rd;
            check("rdata", bus_read_data, exp_rdata);
            check("err", {31'b0, bus_err}, {31'b0, exp_err});
            @(posedge clk); #1;
        end
        if (wr)
            for (int b = 0; b < 4; b++)
                if (be[b]) ref_mem[w[7:0]][b*8 +: 8] = d[b*8 +: 8];
    endtask

    task automatic idle(input int n);
        bus_read = 1'b0; bus_write = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("gap_stall", {31'b0, bus_stall}, 32'd0);
            check("gap_ce_n", {31'b0, sram_ce_n}, 32'd1);
            check("gap_be_n", {28'b0, sram_be_n}, 32'hF);
            check("gap_rdata", bus_read_data, exp_rdata);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int c0;
        bit wr;
        logic [31:0] a;
        rst = 1'b1; mem_init = 1'b1;
        bus_addr = '0; bus_write_data = '0; bus_byte_en = '0; bus_read = 1'b0; bus_write = 1'b0;
        d1_bus_addr = '0; d1_bus_write_data = '0; d1_bus_byte_en = '0;
        d1_bus_read = 1'b0; d1_bus_write = 1'b0;
        exp_rdata = '0; exp_err = 1'b0;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        @(posedge clk); @(posedge clk); #1;
        mem_init = 1'b0;
        check("rst_rdata", bus_read_data, 32'd0);
        check("rst_addr", {12'b0, sram_addr}, 32'd0);
        check("rst_data_o", sram_data_o, 32'd0);
        check("rst_oe", {31'b0, sram_data_oe}, 32'd0);
        check("rst_ce_n", {31'b0, sram_ce_n}, 32'd1);
        check("rst_oe_n", {31'b0, sram_oe_n}, 32'd1);
        check("rst_we_n", {31'b0, sram_we_n}, 32'd1);
        check("rst_be_n", {28'b0, sram_be_n}, 32'hF);
        check("rst_err", {31'b0, bus_err}, 32'd0);
        check("rst_stall", {31'b0, bus_stall}, 32'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        // Directed read of the 0xDEADBEEF word, then a partial write and read-back.
        txn(1'b0, 32'h80000010, 32'h0, 4'hF);
        check("read_deadbeef", bus_read_data, 32'hDEADBEEF);
        txn(1'b1, 32'h80000008, 32'h12345678, 4'b0011);
        idle(1);
        txn(1'b0, 32'h80000008, 32'h0, 4'hF);
        check("partial_wr", bus_read_data, {init_word(2) & 32'hFFFF0000} | 32'h00005678);

        // Back-to-back reads: 12 cycles in total.
        idle(1);
        c0 = cyc;
        txn(1'b0, 32'h00000000, 32'h0, 4'hF);
        txn(1'b0, 32'h00000004, 32'h0, 4'hF);
        check("b2b_cycles", cyc - c0, 32'd12);
        idle(1);

        // Read dropped in its second access cycle.
        bus_addr = 32'h00000014; bus_byte_en = 4'hF; bus_read = 1'b1; bus_write = 1'b0;
        @(negedge clk); check("drop_stall0", {31'b0, bus_stall}, 32'd1);
        @(posedge clk); #1;
        @(negedge clk); check("drop_oe_n1", {31'b0, sram_oe_n}, 32'd0);
        @(posedge clk); #1;
        bus_read = 1'b0;
        @(negedge clk); check("drop_stall2", {31'b0, bus_stall}, 32'd0);
        @(posedge clk); #1;
`ifdef BUS_PROTOCOL_CHECK_EN
        exp_err = 1'b1;
`endif
        @(negedge clk);
        check("drop_ce_n", {31'b0, sram_ce_n}, 32'd1);
        check("drop_oe_n", {31'b0, sram_oe_n}, 32'd1);
        check("drop_be_n", {28'b0, sram_be_n}, 32'hF);
        check("drop_rdata", bus_read_data, exp_rdata);
        check("drop_err", {31'b0, bus_err}, {31'b0, exp_err});
        @(posedge clk); #1;
        idle(1);

        // Randomized traffic against the reference memory.
        for (int n = 0; n < 24; n++) begin
            wr = 1'($urandom_range(0, 1));
            a = ($urandom & 32'hFFC00003) | ($urandom_range(0, 239) << 2);
            txn(wr, a, $urandom, 4'($urandom_range(0, 15)));
            if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 2));
        end
        idle(1);

        // Reset pulse in the second cycle of a write.
        bus_addr = 32'h000003C0; bus_write_data = 32'hCAFEF00D; bus_byte_en = 4'hF;
        bus_write = 1'b1; bus_read = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        check("mrst_we_n", {31'b0, sram_we_n}, 32'd1);
        check("mrst_oe", {31'b0, sram_data_oe}, 32'd0);
        check("mrst_ce_n", {31'b0, sram_ce_n}, 32'd1);
        check("mrst_be_n", {28'b0, sram_be_n}, 32'hF);
        check("mrst_addr", {12'b0, sram_addr}, 32'd0);
        check("mrst_data_o", sram_data_o, 32'd0);
        check("mrst_rdata", bus_read_data, 32'd0);
        check("mrst_err", {31'b0, bus_err}, 32'd0);
        check("mrst_stall", {31'b0, bus_stall}, 32'd1);
        @(posedge clk); #1;
        bus_write = 1'b0; rst = 1'b0;
        exp_rdata = '0; exp_err = 1'b0;
        idle(2);

        // WAIT_CYCLE=1 instance with read and write both requested.
        d1_bus_addr = 32'h80000020; d1_bus_write_data = 32'h0BADC0DE; d1_bus_byte_en = 4'hF;
        d1_bus_read = 1'b1; d1_bus_write = 1'b1;
        for (int k = 0; k <= 2; k++) begin
            @(negedge clk);
            check("w1_stall", {31'b0, d1_bus_stall}, {31'b0, (k <= 1)});
            check("w1_we_n", {31'b0, d1_sram_we_n}, 32'd1);
            check("w1_ce_n", {31'b0, d1_sram_ce_n}, {31'b0, (k != 1)});
            check("w1_oe", {31'b0, d1_sram_data_oe}, {31'b0, (k == 1)});
            check("w1_oe_n", {31'b0, d1_sram_oe_n}, 32'd1);
            check("w1_rdata", d1_bus_read_data, 32'd0);
            if (k == 1) begin
                check("w1_addr", {12'b0, d1_sram_addr}, 32'h8);
                check("w1_data_o", d1_sram_data_o, 32'h0BADC0DE);
                check("w1_be_n", {28'b0, d1_sram_be_n}, 32'd0);
            end
`ifdef BUS_PROTOCOL_CHECK_EN
            check("w1_err", {31'b0, d1_bus_err}, {31'b0, (k >= 1)});
`else
            check("w1_err", {31'b0, d1_bus_err}, 32'd0);
`endif
            @(posedge clk); #1;
        end
        d1_bus_read = 1'b0; d1_bus_write = 1'b0;
        @(posedge clk); #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
